// File: rtl/mult_stage_pipe_if.sv
// mult_stage_pipe_if: handshake and data bundle for the PE multiply stage.
//   Upstream (FS -> MS): i_fs_rdy / o_fs_ack, i_signed, i_acc, i_ctl,
//                        i_ipix, i_wpix, i_psum
//   Downstream (MS -> SS): o_ms_rdy / i_ms_ack, o_psum, o_sum, o_ctl
//   o_sat exists only when MS_PSUM_SAT_EN is defined.
// Modports: master = the side driving the stage (FS + SS), slave = the stage.
interface mult_stage_pipe_if #(
    parameter int DWD   = 8,
    parameter int NMAC  = 4,
    parameter int NROW  = 4,
    parameter int PSUMW = 24,
    parameter int CTLW  = 8
);
    localparam int SUMW = 2*DWD + $clog2(NMAC);

    logic                      i_fs_rdy;
    logic                      o_fs_ack;
    logic                      o_ms_rdy;
    logic                      i_ms_ack;
    logic                      i_signed;
    logic                      i_acc;
    logic [CTLW-1:0]           i_ctl;
    logic [NROW*NMAC*DWD-1:0]  i_ipix;
    logic [NROW*NMAC*DWD-1:0]  i_wpix;
    logic [NROW*PSUMW-1:0]     i_psum;
    logic [NROW*PSUMW-1:0]     o_psum;
    logic [NROW*SUMW-1:0]      o_sum;
    logic [CTLW-1:0]           o_ctl;
`ifdef MS_PSUM_SAT_EN
    logic [NROW-1:0]           o_sat;

    modport master (
        output i_fs_rdy, i_ms_ack, i_signed, i_acc, i_ctl, i_ipix, i_wpix, i_psum,
        input  o_fs_ack, o_ms_rdy, o_psum, o_sum, o_ctl, o_sat
    );
    modport slave (
        input  i_fs_rdy, i_ms_ack, i_signed, i_acc, i_ctl, i_ipix, i_wpix, i_psum,
        output o_fs_ack, o_ms_rdy, o_psum, o_sum, o_ctl, o_sat
    );
`else
    modport master (
        output i_fs_rdy, i_ms_ack, i_signed, i_acc, i_ctl, i_ipix, i_wpix, i_psum,
        input  o_fs_ack, o_ms_rdy, o_psum, o_sum, o_ctl
    );
    modport slave (
        input  i_fs_rdy, i_ms_ack, i_signed, i_acc, i_ctl, i_ipix, i_wpix, i_psum,
        output o_fs_ack, o_ms_rdy, o_psum, o_sum, o_ctl
    );
`endif
endinterface

// File: rtl/mult_stage_pipe.sv
// mult_stage_pipe: PE multiply stage between fetch (FS) and sum (SS) stages.
//   Each of NROW lanes multiplies NMAC operand pairs, reduces them to a
//   SUMW-bit signed sum and either passes it beside the incoming partial sum
//   (i_acc=0) or adds it into the partial sum (i_acc=1). Results flow through
//   a LAT-deep elastic pipeline with rdy/ack flow control; i_ctl rides along.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   bus (slave)    : FS/SS handshake, operands, partial sums, control word
// Optional: define MS_PSUM_SAT_EN for saturating accumulate plus the sticky
//   per-lane o_sat flags (cleared by reset or a transfer with i_ctl MSB set).
module mult_stage_pipe #(
    parameter int DWD   = 8,
    parameter int NMAC  = 4,
    parameter int NROW  = 4,
    parameter int PSUMW = 24,
    parameter int LAT   = 2,
    parameter int CTLW  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    mult_stage_pipe_if.slave bus
);
    localparam int SUMW  = 2*DWD + $clog2(NMAC);
    localparam int PW    = 2*DWD;
    // With LAT>=2 stage 0 holds raw products and the reduction lands in
    // stage 1; with LAT=1 everything is computed in front of stage 0.
    localparam int FIRST = (LAT == 1) ? 0 : 1;
    localparam int NRES  = LAT - FIRST;

    typedef logic [NROW-1:0][NMAC-1:0][PW-1:0] prod_t;

    logic [NROW-1:0][NMAC-1:0][DWD-1:0]    ipix, wpix;
    prod_t                                 prod_c, src_prod;
    logic [NROW-1:0][PSUMW-1:0]            src_psum, red_psum;
    logic [NROW-1:0][SUMW-1:0]             red_sum;
    logic                                  src_sgn, src_acc;

    logic [LAT-1:0]                        vld_pipe, adv, load;
    logic                                  fs_ack;
    logic [LAT-1:0][CTLW-1:0]              ctl_q;
    logic [NRES-1:0][NROW-1:0][PSUMW-1:0]  res_psum;
    logic [NRES-1:0][NROW-1:0][SUMW-1:0]   res_sum;

    assign ipix = bus.i_ipix;
    assign wpix = bus.i_wpix;

    // Ready ripples backward from the sink: a stage advances when it is full
    // and the next one can take it (empty or itself advancing).
    always_comb begin : p_hs
        logic rdy_nxt;
        adv     = '0;
        load    = '0;
        rdy_nxt = bus.i_ms_ack;
        for (int s = LAT-1; s >= 0; s--) begin
            adv[s]  = vld_pipe[s] & rdy_nxt;
            rdy_nxt = ~vld_pipe[s] | adv[s];
        end
        fs_ack  = rdy_nxt;
        load[0] = bus.i_fs_rdy & rdy_nxt;
        for (int s = 1; s < LAT; s++) load[s] = adv[s-1];
    end

    // Operands are widened by one bit so a single signed multiply covers
    // both signed and unsigned modes; the low PW bits are the product.
    for (genvar l = 0; l < NROW; l++) begin : g_mul
        for (genvar k = 0; k < NMAC; k++) begin : g_mac
            logic signed [DWD:0] a, b;
            assign a = {bus.i_signed & ipix[l][k][DWD-1], ipix[l][k]};
            assign b = {bus.i_signed & wpix[l][k][DWD-1], wpix[l][k]};
            assign prod_c[l][k] = PW'(a * b);
        end
    end

    if (LAT == 1) begin : g_front_comb
        assign src_prod = prod_c;
        assign src_psum = bus.i_psum;
        assign src_sgn  = bus.i_signed;
        assign src_acc  = bus.i_acc;
    end else begin : g_front_reg
        prod_t                      prod_q;
        logic [NROW-1:0][PSUMW-1:0] psum_q;
        logic                       sgn_q, acc_q;
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                prod_q <= '0;
                psum_q <= '0;
                sgn_q  <= 1'b0;
                acc_q  <= 1'b0;
            end else if (load[0]) begin
                prod_q <= prod_c;
                psum_q <= bus.i_psum;
                sgn_q  <= bus.i_signed;
                acc_q  <= bus.i_acc;
            end
        end
        assign src_prod = prod_q;
        assign src_psum = psum_q;
        assign src_sgn  = sgn_q;
        assign src_acc  = acc_q;
    end

`ifdef MS_PSUM_SAT_EN
    logic [NROW-1:0] red_sat, sat_q;
`endif

    for (genvar l = 0; l < NROW; l++) begin : g_red
        logic [SUMW-1:0]  sum_l;
        logic [PSUMW-1:0] acc_l;

        // SUMW has log2(NMAC) guard bits, so the reduction cannot overflow.
        always_comb begin
            sum_l = '0;
            for (int k = 0; k < NMAC; k++)
                sum_l = sum_l + (src_sgn ? SUMW'($signed(src_prod[l][k]))
                                         : SUMW'(src_prod[l][k]));
        end

`ifdef MS_PSUM_SAT_EN
        logic [PSUMW:0] wide;
        logic           ovf;
        // One extra bit exposes signed overflow as a top-two-bit mismatch.
        always_comb begin
            wide  = (PSUMW+1)'($signed(src_psum[l])) + (PSUMW+1)'($signed(sum_l));
            ovf   = wide[PSUMW] ^ wide[PSUMW-1];
            acc_l = wide[PSUMW-1:0];
            if (ovf)
                acc_l = wide[PSUMW] ? {1'b1, {(PSUMW-1){1'b0}}}
                                    : {1'b0, {(PSUMW-1){1'b1}}};
        end
        assign red_sat[l] = src_acc & ovf;
`else
        assign acc_l = src_psum[l] + PSUMW'($signed(sum_l));
`endif

        assign red_psum[l] = src_acc ? acc_l : src_psum[l];
        assign red_sum[l]  = src_acc ? '0    : sum_l;
    end

    // Payload registers only change on load, which also keeps the output
    // stage frozen while the sink stalls.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vld_pipe <= '0;
            ctl_q    <= '0;
            res_psum <= '0;
            res_sum  <= '0;
        end else begin
            for (int s = 0; s < LAT; s++) begin
                if (load[s])     vld_pipe[s] <= 1'b1;
                else if (adv[s]) vld_pipe[s] <= 1'b0;
            end
            if (load[0]) ctl_q[0] <= bus.i_ctl;
            for (int s = 1; s < LAT; s++)
                if (load[s]) ctl_q[s] <= ctl_q[s-1];
            if (load[FIRST]) begin
                res_psum[0] <= red_psum;
                res_sum[0]  <= red_sum;
            end
            for (int j = 1; j < NRES; j++) begin
                if (load[FIRST+j]) begin
                    res_psum[j] <= res_psum[j-1];
                    res_sum[j]  <= res_sum[j-1];
                end
            end
        end
    end

`ifdef MS_PSUM_SAT_EN
    // Clear and set in the same cycle: the new saturation event wins.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            sat_q <= '0;
        else
            sat_q <= ((load[0] & bus.i_ctl[CTLW-1]) ? '0 : sat_q)
                   | (load[FIRST] ? red_sat : '0);
    end
    assign bus.o_sat = sat_q;
`endif

    assign bus.o_fs_ack = fs_ack;
    assign bus.o_ms_rdy = vld_pipe[LAT-1];
    assign bus.o_ctl    = ctl_q[LAT-1];
    assign bus.o_psum   = res_psum[NRES-1];
    assign bus.o_sum    = res_sum[NRES-1];
endmodule

// File: tb/tb_mult_stage_pipe.sv
// tb_mult_stage_pipe: scoreboard bench for mult_stage_pipe (LAT=2 build).
// Lane 0 and lane 3 carry the same directed operands, lanes 1/2 carry zero
// operands with pass-through partial sums 1 and 2.
module tb_mult_stage_pipe;
    localparam int DWD   = 8;
    localparam int NMAC  = 4;
    localparam int NROW  = 4;
    localparam int PSUMW = 24;
    localparam int LAT   = 2;
    localparam int CTLW  = 8;
    localparam int SUMW  = 2*DWD + $clog2(NMAC);

`ifdef MS_PSUM_SAT_EN
    localparam logic [PSUMW-1:0] EXP_POS_OVF = 24'h7FFFFF;
    localparam logic [PSUMW-1:0] EXP_NEG_OVF = 24'h800000;
`else
    localparam logic [PSUMW-1:0] EXP_POS_OVF = 24'h800010;
    localparam logic [PSUMW-1:0] EXP_NEG_OVF = 24'h7FFFE5;
`endif

    typedef struct {
        logic [NROW*PSUMW-1:0] psum;
        logic [NROW*SUMW-1:0]  sum;
        logic [CTLW-1:0]       ctl;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_stage_pipe_if #(.DWD(DWD), .NMAC(NMAC), .NROW(NROW), .PSUMW(PSUMW), .CTLW(CTLW)) bus();

    mult_stage_pipe #(.DWD(DWD), .NMAC(NMAC), .NROW(NROW), .PSUMW(PSUMW), .LAT(LAT), .CTLW(CTLW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   ack_mode = 0;   // 0: always 1, 1: toggle, 2: always 0
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream ack, changes 2 time units after the falling edge.
    initial begin
        bus.i_ms_ack = 1'b1;
        forever begin
            @(negedge clk);
            #2;
            case (ack_mode)
                0:       bus.i_ms_ack = 1'b1;
                1:       bus.i_ms_ack = ~bus.i_ms_ack;
                default: bus.i_ms_ack = 1'b0;
            endcase
        end
    end

    // Monitor: pops on every output transfer, checks stability while stalled.
    initial begin
        logic                 held;
        logic [NROW*PSUMW-1:0] hp;
        logic [NROW*SUMW-1:0]  hs;
        logic [CTLW-1:0]       hc;
        exp_t                  e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (!mon_en) begin
                held = 1'b0;
                continue;
            end
            if (held) begin
                chk("hold_rdy",  128'(bus.o_ms_rdy), 128'(1));
                chk("hold_psum", 128'(bus.o_psum), 128'(hp));
                chk("hold_sum",  128'(bus.o_sum), 128'(hs));
                chk("hold_ctl",  128'(bus.o_ctl), 128'(hc));
            end
            if (bus.o_ms_rdy && bus.i_ms_ack) begin
                held = 1'b0;
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got psum %0h with empty queue, expected no output", bus.o_psum);
                end else begin
                    e = sbq.pop_front();
                    chk("out_psum", 128'(bus.o_psum), 128'(e.psum));
                    chk("out_sum",  128'(bus.o_sum), 128'(e.sum));
                    chk("out_ctl",  128'(bus.o_ctl), 128'(e.ctl));
                end
            end else if (bus.o_ms_rdy) begin
                held = 1'b1;
                hp = bus.o_psum;
                hs = bus.o_sum;
                hc = bus.o_ctl;
            end else begin
                held = 1'b0;
            end
        end
    end

    // Drive one transfer; returns just after the accepting rising edge.
    task automatic send(input logic [31:0] ip0, input logic [31:0] wp0,
                        input logic sg, input logic ac,
                        input logic [PSUMW-1:0] ps0, input logic [CTLW-1:0] ct,
                        input logic [PSUMW-1:0] eps0, input logic [SUMW-1:0] es0);
        logic [NROW-1:0][NMAC*DWD-1:0] ip, wp;
        logic [NROW-1:0][PSUMW-1:0]    ps, eps;
        logic [NROW-1:0][SUMW-1:0]     es;
        exp_t e;
        bit   taken;
        int   n;
        ip = '0; wp = '0; es = '0;
        ip[0] = ip0; ip[3] = ip0;
        wp[0] = wp0; wp[3] = wp0;
        ps[0] = ps0; ps[1] = 24'd1; ps[2] = 24'd2; ps[3] = ps0;
        eps[0] = eps0; eps[1] = 24'd1; eps[2] = 24'd2; eps[3] = eps0;
        es[0] = es0; es[3] = es0;
        @(negedge clk);
        bus.i_ipix   = ip;
        bus.i_wpix   = wp;
        bus.i_psum   = ps;
        bus.i_signed = sg;
        bus.i_acc    = ac;
        bus.i_ctl    = ct;
        bus.i_fs_rdy = 1'b1;
        e.psum = eps; e.sum = es; e.ctl = ct;
        sbq.push_back(e);
        n = 0;
        taken = 1'b0;
        while (!taken) begin
            #4;
            taken = bus.o_fs_ack;
            @(posedge clk);
            if (!taken) begin
                n++;
                if (n >= 100) begin
                    total++;
                    bad++;
                    $display("FAIL accept_timeout: got no o_fs_ack in %0d cycles, expected accept", n);
                    void'(sbq.pop_back());
                    break;
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic stop_fs();
        #1;
        bus.i_fs_rdy = 1'b0;
    endtask

    initial begin
        bus.i_fs_rdy = 1'b1;
        bus.i_signed = 1'b0;
        bus.i_acc    = 1'b0;
        bus.i_ctl    = '0;
        bus.i_ipix   = '0;
        bus.i_wpix   = '0;
        bus.i_psum   = '0;
        rst_n = 1'b0;

        // Reset held 3 cycles with upstream valid
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ms_rdy", 128'(bus.o_ms_rdy), 128'(0));
        chk("rst_psum",   128'(bus.o_psum), 128'(0));
        chk("rst_sum",    128'(bus.o_sum), 128'(0));
        chk("rst_ctl",    128'(bus.o_ctl), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_fs_rdy = 1'b0;
        @(posedge clk);
        #1;
        chk("ack_after_rst", 128'(bus.o_fs_ack), 128'(1));
        mon_en = 1'b1;

        // Signed {-3,2,1,0}.{4,5,-7,9} = -9, with latency check
        send(32'h000102FD, 32'h09F90504, 1'b1, 1'b0, 24'h123456, 8'h5A, 24'h123456, 18'h3FFF7);
        stop_fs();
        for (int i = 0; i < LAT-1; i++) begin
            chk("lat_early", 128'(bus.o_ms_rdy), 128'(0));
            @(posedge clk);
            #1;
        end
        chk("lat_due", 128'(bus.o_ms_rdy), 128'(1));
        repeat (3) @(posedge clk);

        // Unsigned same bytes = 1271; extreme products; accumulate cases
        send(32'h000102FD, 32'h09F90504, 1'b0, 1'b0, 24'h123456, 8'h3C, 24'h123456, 18'd1271);
        send(32'h80808080, 32'h7F7F7F7F, 1'b1, 1'b0, 24'h000000, 8'h11, 24'h000000, 18'h30200);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 24'h000AAA, 8'h22, 24'h000AAA, 18'h3F804);
        send(32'h00000004, 32'h00000008, 1'b1, 1'b1, 24'h7FFFF0, 8'h01, EXP_POS_OVF, 18'h0);
        send(32'h000000FC, 32'h00000008, 1'b1, 1'b1, 24'h000010, 8'h02, 24'hFFFFF0, 18'h0);
        send(32'h000000FC, 32'h00000008, 1'b1, 1'b1, 24'h800005, 8'h03, EXP_NEG_OVF, 18'h0);
        stop_fs();
        repeat (5) @(posedge clk);
`ifdef MS_PSUM_SAT_EN
        #1 chk("sat_sticky", 128'(bus.o_sat), 128'(4'b1001));
`endif
        // Control MSB set clears the sticky flags
        send(32'h000102FD, 32'h09F90504, 1'b1, 1'b0, 24'h000042, 8'hA5, 24'h000042, 18'h3FFF7);
        stop_fs();
        repeat (5) @(posedge clk);
`ifdef MS_PSUM_SAT_EN
        #1 chk("sat_clear", 128'(bus.o_sat), 128'(0));
`endif

        // 16 back-to-back with toggling downstream ack
        ack_mode = 1;
        for (int i = 0; i < 16; i++)
            send(32'(i+1), 32'd3, 1'b1, 1'b0, 24'(i), 8'(i), 24'(i), 18'(3*(i+1)));
        stop_fs();
        ack_mode = 0;
        for (int i = 0; i < 200 && sbq.size() != 0; i++) @(posedge clk);
        chk("stream_drained", 128'(sbq.size()), 128'(0));
        repeat (2) @(posedge clk);

        // Fill with output stalled, then reset while full
        mon_en = 1'b0;
        ack_mode = 2;
        @(negedge clk);
        bus.i_ipix = '1;
        bus.i_wpix = '1;
        bus.i_ctl  = 8'h77;
        bus.i_acc  = 1'b0;
        bus.i_fs_rdy = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk);
            @(negedge clk);
            #4;
            chk($sformatf("stall_ack_%0d", k), 128'(bus.o_fs_ack), 128'(k < LAT));
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_full_rdy",  128'(bus.o_ms_rdy), 128'(0));
        chk("rst_full_psum", 128'(bus.o_psum), 128'(0));
        chk("rst_full_sum",  128'(bus.o_sum), 128'(0));
        chk("rst_full_ctl",  128'(bus.o_ctl), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_fs_rdy = 1'b0;
        ack_mode = 0;
        sbq.delete();
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_full_ack", 128'(bus.o_fs_ack), 128'(1));
        repeat (6) @(posedge clk);
        chk("no_stale_rdy", 128'(bus.o_ms_rdy), 128'(0));
        chk("queue_empty", 128'(sbq.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_stage_pipe.md
Name: mult_stage_pipe

Overview:
- Parametrised successor to the PE multiply stage. Sits between the fetch stage (FS) and the sum stage (SS) in each PE column.
- Each of NROW lanes multiplies NMAC input/weight pairs and reduces them to one sum. The lane's partial sum is carried alongside, or optionally pre-added to that sum.
- The result travels through a LAT-deep elastic pipeline with rdy/ack flow control. A CTLW-bit control word rides with the data.

Parameters:
- DWD, 8, operand width (input and weight)
- NMAC, 4, multiply pairs per lane per transfer (power of 2, ≥1)
- NROW, 4, number of lanes
- PSUMW, 24, partial-sum width
- LAT, 2, pipeline depth in cycles (1..4)
- CTLW, 8, sideband control word width
- SUMW (derived), 2*DWD+$clog2(NMAC), lane sum width

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_fs_rdy  in  1  upstream data valid
- o_fs_ack  out  1  upstream transfer accepted
- o_ms_rdy  out  1  output data valid
- i_ms_ack  in  1  downstream accepts output
- i_signed  in  1  1 = operands two's complement, 0 = unsigned; sampled with data
- i_acc  in  1  1 = output psum+sum in o_psum; 0 = pass psum, sum separately
- i_ctl  in  CTLW  sideband control word
- i_ipix  in  NROW*NMAC*DWD  input operands, lane-major
- i_wpix  in  NROW*NMAC*DWD  weight operands, lane-major
- i_psum  in  NROW*PSUMW  incoming partial sums
- o_psum  out  NROW*PSUMW  outgoing partial sums
- o_sum  out  NROW*SUMW  lane product sums (signed)
- o_ctl  out  CTLW  delayed control word

Behaviour:
- Handshake:
  - A transfer occurs on a cycle where rdy && ack.
  - Once o_ms_rdy is high, it and all outputs stay stable until i_ms_ack.
  - o_fs_ack may depend combinationally on i_ms_ack; it never depends on i_fs_rdy.
- Pipeline:
  - LAT stages, each holding a valid bit, payload, signed bit and acc bit.
  - A stage loads when it is empty or when its content moves forward in the same cycle.
  - o_fs_ack = stage0 empty OR stage0 advancing.
  - Throughput is 1 transfer per cycle with no bubbles under continuous rdy/ack.
- Latency:
  - Data accepted at edge N appears with o_ms_rdy high after edge N+LAT-1. With LAT=1, it is visible the cycle after acceptance.
  - Stall timing: output held ≥1 cycle delays upstream accept only once all stages are full.
- Arithmetic:
  - Product is 2*DWD wide. Operands are sign- or zero-extended per the sampled i_signed.
  - Sum is the sign-extended SUMW result of all NMAC products, and never overflows.
  - When LAT≥2, multiplication is registered at stage 0 and the reduction at stage 1. Remaining stages are delay only.
  - With i_acc=1: o_psum = i_psum + sign-extended sum, truncated (wrap) to PSUMW, and o_sum = 0.
  - With i_acc=0: o_psum = i_psum and o_sum = sum.
- Reset (i_rst_n low at a clock edge):
  - All valid bits clear; o_ms_rdy=0; o_psum, o_sum and o_ctl = 0.
  - In-flight data is discarded with no partial output.
  - o_fs_ack is 1 the cycle after reset releases.
- Simultaneous events:
  - Output drain and upstream accept in the same cycle when full is legal. The pipeline stays full and each stage shifts.
- Clock gating: stage registers update only when loading, for power.

Optional Feature:
- Macro MS_PSUM_SAT_EN.
- Defined: in i_acc mode the psum+sum addition saturates to the signed PSUMW range. A per-lane sticky bit o_sat[NROW] (additional output port) is set on any saturation event. It is cleared by reset or by a transfer with i_ctl[CTLW-1]=1.
- Undefined: the addition wraps, and the o_sat port does not exist.

Test Plan:
- Reset: hold i_rst_n=0 for 3 cycles with i_fs_rdy=1 -> o_ms_rdy=0 and outputs 0; o_fs_ack=1 one cycle after release.
- Latency, LAT=2, signed: ipix lane0={-3,2,1,0} and wpix={4,5,-7,9} -> o_sum lane0 = -9 exactly 2 cycles after accept; o_ctl matches the input.
- Unsigned mode with the same bytes (0xFD, ..., 0xF9) -> lane0 sum = 0xFD*4+2*5+1*0xF9 = 1271.
- Back-to-back stream of 16 transfers, i_ms_ack toggling 1-0-1: all 16 arrive in order, none lost or duplicated; o_ms_rdy and data are stable while ack is low.
- Acc mode: i_psum=0x7FFFF0 (PSUMW=24), sum=+0x20 -> 0x800010 (wrap) without the macro; 0x7FFFFF with o_sat[lane]=1 with MS_PSUM_SAT_EN defined.
- Reset asserted with the pipeline full and output stalled -> all valids clear on the next edge, and no stale output after release.
